gcd_operand_sequencer: RTL
==========================

# gcd_operand_sequencer

Upstream front end for the subtractive GCD engine (`gcd_controller` plus its datapath).
- Accepts operand pairs over a valid/ready interface and buffers them in a 2-entry FIFO.
- Serialises each pair onto the engine's shared `data_in` bus with the `start` pulse, waits for `done` under a watchdog, captures the result and returns it downstream over valid/ready.
- Zero operands are resolved locally, because the subtractive engine never terminates on them.

## Interface
- `WIDTH`, 16, operand/result width
- `MAX_CYCLES`, 1024, watchdog limit on RUN cycles per job
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  operand pair offered
- `in_ready`  out  1  FIFO not full
- `in_a`, `in_b`  in  WIDTH  operands
- `data_in`  out  WIDTH  engine operand bus
- `start`  out  1  engine start, one cycle
- `gcd_clr`  out  1  engine clear; engine returns to its idle/load-A state
- `done`  in  1  engine finished
- `gcd_result`  in  WIDTH  engine A register, valid while `done`=1
- `out_valid`  out  1  result offered
- `out_ready`  in  1  downstream accepts
- `out_data`  out  WIDTH  GCD result
- `out_timeout`  out  1  qualifies `out_data`; 1 = watchdog expired, `out_data`=0
- `busy`  out  1  state != IDLE or FIFO non-empty

## Operation
- FIFO: 2 entries of {a,b}.
  - Push on `in_valid && in_ready`; `in_ready` = !full.
  - Pop only in IDLE.
  - A push and a pop in the same cycle are legal.
  - An entry pushed at edge E is poppable at E+1.
- States: CLEAR, IDLE, LOAD_A, LOAD_B, RUN, HOLD.
- CLEAR: `gcd_clr`=1 for exactly one cycle, then IDLE.
- IDLE, at an edge with the FIFO non-empty, pops the head into the operand registers:
  - a==0 or b==0: result = a|b (0 for (0,0)), `out_timeout`=0, go to HOLD. Engine is untouched.
  - Otherwise go to LOAD_A.
- LOAD_A: `data_in`=A, `start`=1; engine loads A on this edge. Next state LOAD_B.
- LOAD_B: `data_in`=B; engine loads B. Next state RUN, watchdog counter cleared to 0.
- RUN: counter increments each cycle.
  - `done`=1: capture `gcd_result`, `out_timeout`=0, go to HOLD.
  - Counter == MAX_CYCLES-1 without `done`: result 0, `out_timeout`=1, go to HOLD.
  - If `done` and the limit coincide, `done` wins.
- HOLD: `out_valid`=1; `out_data`/`out_timeout` stable until `out_ready`. On the handshake:
  - to CLEAR if the engine was started for this job;
  - to IDLE for the zero bypass.
- `data_in`=0 outside LOAD_A/LOAD_B.
- Counter width: $clog2(MAX_CYCLES+1).

## Timing
- Reset values (held during `rst`):
  - state=CLEAR, FIFO empty, counter 0;
  - `gcd_clr`=1, `in_ready`=1, `start`=0, `data_in`=0, `out_valid`=0, `out_data`=0, `out_timeout`=0, `busy`=1.
- First cycle after reset release: CLEAR (`gcd_clr`=1), then IDLE.
- Reset mid-job discards the FIFO and the in-flight result; the engine is flushed by the CLEAR cycle.
- Engine latency: push E0; pop E1; LOAD_A cycle E1–E2 (`start` high); LOAD_B cycle E2–E3; RUN from E3.
  - `out_valid` rises the cycle after `done` is sampled.
- Zero bypass: push E0, pop E1, `out_valid` from E1.
- Back-to-back engine jobs are separated by HOLD handshake + 1 CLEAR cycle + 1 IDLE cycle.
- `start` is never asserted in the same cycle as `gcd_clr`.

## Structure
- Package `gcd_pkg` contains:
  - state enum `gcd_seq_state_t`;
  - default `WIDTH`;
  - operand pair struct {a,b}.
- Sub-module `gcd_pair_fifo`: 2-entry, WIDTH*2 wide, with full/empty flags, async reset. It is reusable on the result side later.
- Top level holds the FSM, operand registers, watchdog and result register. Target 150–250 lines total.

## Test plan
- (48,18), engine model raises `done` with `gcd_result`=6 after 5 RUN cycles:
  - `start` 1 cycle with `data_in`=48, next cycle `data_in`=18;
  - `out_data`=6, `out_timeout`=0;
  - `gcd_clr` pulse one cycle after the handshake.
- (0,35) then (0,0):
  - `out_data`=35, then 0;
  - `start` and `gcd_clr` never asserted;
  - `out_valid` in the pop cycle.
- `out_ready`=0, pairs (12,8),(9,6),(10,4),(14,21) offered back-to-back:
  - first three accepted (1 in flight, 2 buffered);
  - `in_ready`=0 on the fourth until HOLD drains;
  - results 4,3,2,7 in order.
- MAX_CYCLES=8, `done` held low:
  - `out_valid` with `out_timeout`=1 and `out_data`=0 at the 8th RUN cycle;
  - then CLEAR, then the next job proceeds normally.
- `rst` pulsed during RUN of (15,10):
  - all outputs at reset values;
  - FIFO empty;
  - `gcd_clr`=1 for one cycle after release;
  - no result emitted.
- (7,7) with `done` on the first RUN cycle: `out_data`=7; `done` and watchdog limit coinciding (MAX_CYCLES=1) gives `out_timeout`=0.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types for the GCD operand sequencer.
//   GCD_WIDTH       : default operand/result width
//   gcd_seq_state_t : sequencer FSM state encoding
//   gcd_pair_t      : operand pair {a,b} at the default width
package gcd_pkg;

  localparam int unsigned GCD_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_CLEAR  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_LOAD_A = 3'd2,
    ST_LOAD_B = 3'd3,
    ST_RUN    = 3'd4,
    ST_HOLD   = 3'd5
  } gcd_seq_state_t;

  typedef struct packed {
    logic [GCD_WIDTH-1:0] a;
    logic [GCD_WIDTH-1:0] b;
  } gcd_pair_t;

endpackage

// File: rtl/gcd_pair_fifo.sv
// Two-entry FIFO with full/empty flags and occupancy count.
//   clk, rst         : clock, asynchronous active-high reset
//   push_i, wdata_i  : write strobe/data (ignored when full)
//   pop_i, rdata_o   : read strobe (ignored when empty), head data
//   full_o, empty_o  : occupancy flags
//   count_o          : current occupancy (0..2)
module gcd_pair_fifo #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [1:0]    count_o
);

  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    count_q;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= !wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= !rd_ptr_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/gcd_operand_sequencer.sv
// Front end for the subtractive GCD engine: buffers operand pairs, feeds
// them to the engine over data_in/start, watches for done under a
// watchdog and returns the result over valid/ready. Zero operands are
// answered locally since the engine would never finish on them.
//   clk, rst                      : clock, asynchronous active-high reset
//   in_valid/in_ready/in_a/in_b   : operand pair input
//   data_in/start/gcd_clr         : engine control
//   done/gcd_result               : engine status/result
//   out_valid/out_ready/out_data  : result output
//   out_timeout                   : result came from watchdog expiry
//   busy                          : job in flight or FIFO non-empty
module gcd_operand_sequencer
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH      = GCD_WIDTH,
  parameter int unsigned MAX_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] data_in,
  output logic             start,
  output logic             gcd_clr,
  input  logic             done,
  input  logic [WIDTH-1:0] gcd_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_timeout,
  output logic             busy
);

  localparam int unsigned    CW       = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0]  WD_LIMIT = CW'(MAX_CYCLES - 1);

  gcd_seq_state_t   state_q, state_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    wd_q, wd_d;
  logic             started_q, started_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_timeout_q, out_timeout_d;
  logic [WIDTH-1:0] data_in_q, data_in_d;
  logic             start_q, start_d;
  logic             gcd_clr_q, gcd_clr_d;
  logic             busy_q, busy_d;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [1:0]         fifo_cnt;
  logic [1:0]         fifo_cnt_d;
  logic [2*WIDTH-1:0] fifo_rdata;
  logic [WIDTH-1:0]   head_a;
  logic [WIDTH-1:0]   head_b;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full;
  assign head_a    = fifo_rdata[2*WIDTH-1:WIDTH];
  assign head_b    = fifo_rdata[WIDTH-1:0];

  gcd_pair_fifo #(
    .DW (2*WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({in_a, in_b}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d       = state_q;
    b_d           = b_q;
    wd_d          = wd_q;
    started_d     = started_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_timeout_d = out_timeout_q;
    data_in_d     = '0;
    fifo_pop      = 1'b0;

    case (state_q)
      ST_CLEAR: state_d = ST_IDLE;
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          b_d      = head_b;
          if ((head_a == '0) || (head_b == '0)) begin
            // Local answer: gcd(x,0) = x, gcd(0,0) reported as 0
            out_data_d    = head_a | head_b;
            out_timeout_d = 1'b0;
            out_valid_d   = 1'b1;
            started_d     = 1'b0;
            state_d       = ST_HOLD;
          end else begin
            data_in_d = head_a;
            started_d = 1'b1;
            state_d   = ST_LOAD_A;
          end
        end
      end
      ST_LOAD_A: begin
        data_in_d = b_q;
        state_d   = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        wd_d    = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        wd_d = wd_q + CW'(1);
        // done takes priority over a coincident watchdog expiry
        if (done) begin
          out_data_d    = gcd_result;
          out_timeout_d = 1'b0;
          out_valid_d   = 1'b1;
          state_d       = ST_HOLD;
        end else if (wd_q == WD_LIMIT) begin
          out_data_d    = '0;
          out_timeout_d = 1'b1;
          out_valid_d   = 1'b1;
          state_d       = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = started_q ? ST_CLEAR : ST_IDLE;
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    case ({fifo_push, fifo_pop})
      2'b10:   fifo_cnt_d = fifo_cnt + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt - 2'd1;
      default: fifo_cnt_d = fifo_cnt;
    endcase

    start_d   = (state_d == ST_LOAD_A);
    gcd_clr_d = (state_d == ST_CLEAR);
    busy_d    = (state_d != ST_IDLE) || (fifo_cnt_d != 2'd0);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_CLEAR;
      b_q           <= '0;
      wd_q          <= '0;
      started_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_timeout_q <= 1'b0;
      data_in_q     <= '0;
      start_q       <= 1'b0;
      gcd_clr_q     <= 1'b1;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      b_q           <= b_d;
      wd_q          <= wd_d;
      started_q     <= started_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_timeout_q <= out_timeout_d;
      data_in_q     <= data_in_d;
      start_q       <= start_d;
      gcd_clr_q     <= gcd_clr_d;
      busy_q        <= busy_d;
    end
  end

  assign data_in     = data_in_q;
  assign start       = start_q;
  assign gcd_clr     = gcd_clr_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_timeout = out_timeout_q;
  assign busy        = busy_q;

endmodule
